// File: rtl/bus_mux_pkg.sv
// Shared types and helpers for the round-robin bus mux/arbiter.
// Holds the FSM encoding, the "no source" select code and the requester search.
package bus_mux_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    localparam int unsigned SEL_NONE  = 0;
    localparam int unsigned MAX_CORES = 32;

    // First set bit of req at or after ptr, wrapping modulo ncores; ptr if none.
    function automatic int unsigned next_req(input logic [MAX_CORES-1:0] req,
                                             input int unsigned          ptr,
                                             input int unsigned          ncores);
        int unsigned idx;
        logic        found;
        found    = 1'b0;
        next_req = ptr;
        for (int unsigned i = 0; i < MAX_CORES; i++) begin
            if (!found && i < ncores) begin
                idx = (ptr + i) % ncores;
                if (|(req & (MAX_CORES'(1) << idx))) begin
                    next_req = idx;
                    found    = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant selection with tenure expiry.
// Keeps the current owner unless it drops its request or its tenure expires while others wait.
module rr_arbiter
    import bus_mux_pkg::*;
#(
    parameter int N  = 3,
    parameter int OW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [OW-1:0] ptr_i,
    input  logic [OW-1:0] owner_i,
    input  logic          owned_i,
    input  logic          expire_i,
    output logic [N-1:0]  gnt_o,
    output logic [OW-1:0] owner_o,
    output logic          owned_o,
    output logic          new_o
);

    logic [N-1:0]  others;
    logic [N-1:0]  cand;
    logic [OW-1:0] pick;

    always_comb begin
        others  = req_i & ~(N'(1) << owner_i);
        cand    = owned_i ? others : req_i;
        pick    = OW'(next_req(MAX_CORES'(cand), 32'(ptr_i), N));
        owned_o = 1'b0;
        owner_o = '0;
        new_o   = 1'b0;
        if (owned_i && req_i[owner_i] && !(expire_i && |others)) begin
            owned_o = 1'b1;
            owner_o = owner_i;
        end else if (|cand) begin
            owned_o = 1'b1;
            owner_o = pick;
            new_o   = 1'b1;
        end
        gnt_o = owned_o ? (N'(1) << owner_o) : '0;
    end

endmodule

// File: rtl/bus_mux_arb.sv
// Multi-core shared bus: round-robin arbitration with bounded tenure and a registered data mux.
// Optional BUS_MUX_PARITY_EN adds a registered even-parity output bus_par tracking bus_data.
module bus_mux_arb
    import bus_mux_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_SRC   = 16,
    parameter int SEL_W     = 5,
    parameter int NUM_CORES = 3,
    parameter int MAX_HOLD  = 4,
    parameter int OWNER_W   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC*DATA_W-1:0]    src_data,
    input  logic [NUM_CORES-1:0]         core_req,
    input  logic [NUM_CORES*SEL_W-1:0]   core_sel,
    output logic [NUM_CORES-1:0]         core_gnt,
    output logic [OWNER_W-1:0]           bus_owner,
    output logic [DATA_W-1:0]            bus_data,
    output logic                         bus_valid,
    output logic                         sel_err
`ifdef BUS_MUX_PARITY_EN
    ,
    output logic                         bus_par
`endif
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int SRC_IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [DATA_W-1:0]    src_arr [NUM_SRC];
    logic [SEL_W-1:0]     sel_arr [NUM_CORES];

    state_t               state_q;
    logic [NUM_CORES-1:0] gnt_q, gnt_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic [OWNER_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]    hold_q;
    logic                 owned_d, new_d, expire;
    logic [DATA_W-1:0]    data_q;
    logic                 valid_q, err_q;
    logic [SEL_W-1:0]     sel_cur;
    logic                 sel_legal;
    logic [SRC_IW-1:0]    src_idx;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign src_arr[i] = src_data[i*DATA_W +: DATA_W];
    end
    for (genvar c = 0; c < NUM_CORES; c++) begin : g_sel
        assign sel_arr[c] = core_sel[c*SEL_W +: SEL_W];
    end

    assign expire = (hold_q == HOLD_W'(MAX_HOLD - 1));
    assign ptr_d  = (owner_d == OWNER_W'(NUM_CORES - 1)) ? '0 : owner_d + OWNER_W'(1);

    rr_arbiter #(
        .N  (NUM_CORES),
        .OW (OWNER_W)
    ) u_arb (
        .req_i    (core_req),
        .ptr_i    (ptr_q),
        .owner_i  (owner_q),
        .owned_i  (state_q == OWNED),
        .expire_i (expire),
        .gnt_o    (gnt_d),
        .owner_o  (owner_d),
        .owned_o  (owned_d),
        .new_o    (new_d)
    );

    // Arbitration state: grant, owner, pointer and tenure counter all move on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= owned_d ? OWNED : IDLE;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            if (new_d) begin
                hold_q <= '0;
                ptr_q  <= ptr_d;
            end else if (!owned_d) begin
                hold_q <= '0;
            end else if (!expire) begin
                hold_q <= hold_q + HOLD_W'(1);
            end
        end
    end

    assign sel_cur   = sel_arr[owner_q];
    assign sel_legal = (sel_cur != SEL_W'(SEL_NONE)) && (sel_cur <= SEL_W'(NUM_SRC));
    assign src_idx   = SRC_IW'(sel_cur - SEL_W'(1));

    // Decode uses the owner that held the bus during the cycle ending at this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (state_q == OWNED) begin
            valid_q <= sel_legal;
            err_q   <= !sel_legal;
            if (sel_legal) begin
                data_q <= src_arr[src_idx];
            end
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end
    end

`ifdef BUS_MUX_PARITY_EN
    logic par_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (state_q == OWNED && sel_legal) begin
            par_q <= ^src_arr[src_idx];
        end
    end
    assign bus_par = par_q;
`endif

    assign core_gnt  = gnt_q;
    assign bus_owner = owner_q;
    assign bus_data  = data_q;
    assign bus_valid = valid_q;
    assign sel_err   = err_q;

endmodule

// File: tb/tb_bus_mux_arb.sv
// Directed bench for bus_mux_arb: cycle table for grant/decode behaviour plus
// hand sequences for round-robin rotation and mid-tenure reset.
module tb_bus_mux_arb;

    localparam int DATA_W    = 8;
    localparam int NUM_SRC   = 16;
    localparam int SEL_W     = 5;
    localparam int NUM_CORES = 3;
    localparam int MAX_HOLD  = 4;
    localparam int OWNER_W   = 2;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NUM_SRC*DATA_W-1:0]   src_data;
    logic [NUM_CORES-1:0]        core_req;
    logic [NUM_CORES*SEL_W-1:0]  core_sel;
    logic [NUM_CORES-1:0]        core_gnt;
    logic [OWNER_W-1:0]          bus_owner;
    logic [DATA_W-1:0]           bus_data;
    logic                        bus_valid;
    logic                        sel_err;
`ifdef BUS_MUX_PARITY_EN
    logic                        bus_par;
`endif

    bus_mux_arb #(
        .DATA_W    (DATA_W),
        .NUM_SRC   (NUM_SRC),
        .SEL_W     (SEL_W),
        .NUM_CORES (NUM_CORES),
        .MAX_HOLD  (MAX_HOLD),
        .OWNER_W   (OWNER_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_data  (src_data),
        .core_req  (core_req),
        .core_sel  (core_sel),
        .core_gnt  (core_gnt),
        .bus_owner (bus_owner),
        .bus_data  (bus_data),
        .bus_valid (bus_valid),
        .sel_err   (sel_err)
`ifdef BUS_MUX_PARITY_EN
        ,
        .bus_par   (bus_par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req;
        logic [4:0] s0, s1, s2;
        logic [2:0] gnt;
        logic [1:0] own;
        logic       vld;
        logic [7:0] data;
        logic       err;
    } vec_t;

    vec_t       vt[$];
    logic [7:0] src [NUM_SRC];
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic vec_t mk(input logic [2:0] req, input logic [4:0] s0, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [2:0] gnt, input logic [1:0] own,
                                input logic vld, input logic [7:0] data, input logic err);
        vec_t v;
        v.req = req; v.s0 = s0; v.s1 = s1; v.s2 = s2;
        v.gnt = gnt; v.own = own; v.vld = vld; v.data = data; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] g, input logic [1:0] o,
                              input logic v, input logic [7:0] d, input logic e);
        chk({tag, ".gnt"},   32'(core_gnt),  32'(g));
        chk({tag, ".owner"}, 32'(bus_owner), 32'(o));
        chk({tag, ".valid"}, 32'(bus_valid), 32'(v));
        chk({tag, ".data"},  32'(bus_data),  32'(d));
        chk({tag, ".err"},   32'(sel_err),   32'(e));
`ifdef BUS_MUX_PARITY_EN
        chk({tag, ".par"},   32'(bus_par),   32'(^d));
`endif
    endtask

    task automatic drive(input logic [2:0] req, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [4:0] s2);
        core_req = req;
        core_sel = {s2, s1, s0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] s;
        rst = 1'b1;
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < NUM_SRC; i++) src[i] = 8'(8'h10 + i);
        src[0]  = 8'hA5;
        src[3]  = 8'h07;
        src[4]  = 8'h03;
        src[15] = 8'h3C;
        for (int i = 0; i < NUM_SRC; i++) src_data[i*DATA_W +: DATA_W] = src[i];

        // Single requester, illegal selects, parity patterns, release to idle.
        vt.push_back(mk(3'b001, 5'd1,  5'd0, 5'd0, 3'b001, 2'd0, 1'b0, 8'h00, 1'b0));
        vt.push_back(mk(3'b001, 5'd1,  5'd0, 5'd0, 3'b001, 2'd0, 1'b1, 8'hA5, 1'b0));
        vt.push_back(mk(3'b001, 5'd0,  5'd0, 5'd0, 3'b001, 2'd0, 1'b0, 8'hA5, 1'b1));
        vt.push_back(mk(3'b001, 5'd17, 5'd0, 5'd0, 3'b001, 2'd0, 1'b0, 8'hA5, 1'b1));
        vt.push_back(mk(3'b001, 5'd16, 5'd0, 5'd0, 3'b001, 2'd0, 1'b1, 8'h3C, 1'b0));
        vt.push_back(mk(3'b001, 5'd4,  5'd0, 5'd0, 3'b001, 2'd0, 1'b1, 8'h07, 1'b0));
        vt.push_back(mk(3'b001, 5'd5,  5'd0, 5'd0, 3'b001, 2'd0, 1'b1, 8'h03, 1'b0));
        vt.push_back(mk(3'b001, 5'd1,  5'd0, 5'd0, 3'b001, 2'd0, 1'b1, 8'hA5, 1'b0));
        vt.push_back(mk(3'b000, 5'd1,  5'd0, 5'd0, 3'b000, 2'd0, 1'b1, 8'hA5, 1'b0));
        vt.push_back(mk(3'b000, 5'd1,  5'd0, 5'd0, 3'b000, 2'd0, 1'b0, 8'hA5, 1'b0));
        // Lone core1 tenure well past MAX_HOLD, changing select every cycle.
        vt.push_back(mk(3'b010, 5'd1,  5'd2, 5'd0, 3'b010, 2'd1, 1'b0, 8'hA5, 1'b0));
        for (int k = 0; k < 9; k++) begin
            s = 5'(2 + (k % 2));
            vt.push_back(mk(3'b010, 5'd1, s, 5'd0, 3'b010, 2'd1, 1'b1, src[s - 5'd1], 1'b0));
        end
        vt.push_back(mk(3'b000, 5'd1,  5'd2, 5'd0, 3'b000, 2'd0, 1'b1, src[1], 1'b0));
        vt.push_back(mk(3'b000, 5'd1,  5'd2, 5'd0, 3'b000, 2'd0, 1'b0, src[1], 1'b0));

        repeat (2) @(posedge clk);
        #1 check_outs("reset", 3'b000, 2'd0, 1'b0, 8'h00, 1'b0);
        @(negedge clk) rst = 1'b0;

        foreach (vt[i]) begin
            @(negedge clk) drive(vt[i].req, vt[i].s0, vt[i].s1, vt[i].s2);
            @(posedge clk);
            #1 check_outs($sformatf("vec%0d", i), vt[i].gnt, vt[i].own, vt[i].vld, vt[i].data, vt[i].err);
        end

        // Fresh reset, then all three cores request at once.
        @(negedge clk) rst = 1'b1;
        @(negedge clk) begin
            rst = 1'b0;
            drive(3'b111, 5'd1, 5'd2, 5'd3);
        end
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1 check_outs($sformatf("rot%0d", k), 3'(3'b001 << ((k / 4) % 3)), 2'((k / 4) % 3),
                          (k >= 1), (k >= 1) ? src[((k - 1) / 4) % 3] : 8'h00, 1'b0);
        end

        // Core2 drops while core0 requests: same-edge handover, then reset mid-tenure.
        @(negedge clk) drive(3'b001, 5'd16, 5'd2, 5'd3);
        @(posedge clk);
        #1 check_outs("hand", 3'b001, 2'd0, 1'b1, src[2], 1'b0);
        @(posedge clk);
        #1 check_outs("src15", 3'b001, 2'd0, 1'b1, 8'h3C, 1'b0);
        #2 rst = 1'b1;
        #1 check_outs("async_rst", 3'b000, 2'd0, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1 check_outs("in_rst", 3'b000, 2'd0, 1'b0, 8'h00, 1'b0);
        @(negedge clk) begin
            rst = 1'b0;
            drive(3'b110, 5'd1, 5'd2, 5'd3);
        end
        @(posedge clk);
        #1 check_outs("post_rst", 3'b010, 2'd1, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1 check_outs("post_rst_data", 3'b010, 2'd1, 1'b1, src[1], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_mux_arb.md
Name: bus_mux_arb

Overview:
Parametrised successor to the single-master combinational bus select used in the multi-core datapath. Multiple cores each request the shared 8-bit internal bus and present an encoded source select. A round-robin arbiter with bounded tenure grants one core, and the selected source word is driven onto a registered bus output. It replaces the latching single-owner mux: illegal selects are detected, and output hold behaviour is defined.

Parameters:
DATA_W, 8, width of every source word and of bus_data
NUM_SRC, 16, number of bus sources; select code i+1 picks source i, code 0 = no source
SEL_W, 5, select code width; must satisfy 2**SEL_W > NUM_SRC
NUM_CORES, 3, number of requesting cores
MAX_HOLD, 4, maximum consecutive granted cycles while another core is waiting (>=1)
OWNER_W, 2, width of bus_owner; must satisfy 2**OWNER_W >= NUM_CORES

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
src_data  in  NUM_SRC*DATA_W  flattened sources; source i at [i*DATA_W +: DATA_W]
core_req  in  NUM_CORES  per-core bus request, level
core_sel  in  NUM_CORES*SEL_W  per-core select code; core c at [c*SEL_W +: SEL_W]
core_gnt  out  NUM_CORES  one-hot grant (all-zero when idle)
bus_owner  out  OWNER_W  index of the granted core; 0 when idle
bus_data  out  DATA_W  registered bus word
bus_valid  out  1  bus_data carries a legal selection this cycle
sel_err  out  1  one-cycle pulse: owner presented code 0 or a code > NUM_SRC

Behaviour:
- Reset (async on rst high):
  - core_gnt=0, bus_owner=0, bus_data=0, bus_valid=0, sel_err=0.
  - Round-robin pointer = 0, hold counter = 0, FSM = IDLE.
- FSM states are IDLE and OWNED.
  - IDLE -> OWNED on any core_req: grant the first requester at or after the pointer (modulo NUM_CORES).
  - OWNED -> IDLE when the owner drops req and no other core is requesting.
  - OWNED -> OWNED (handover) when the owner drops req while others request, or when the tenure expires.
  - Handover is a same-edge switch with no idle gap.
- Grant latency: a request sampled at edge N produces core_gnt at N+1.
- A grant persists while the owner's req stays high.
- Hold counter:
  - Resets to 0 on every new grant and increments each owned cycle.
  - When it reaches MAX_HOLD-1 and another core is requesting, the grant moves to the next requester in round-robin order.
  - If no other core is requesting, the owner keeps the grant and the counter saturates.
- The pointer updates to owner+1 (mod NUM_CORES) on every grant.
- Simultaneous requests resolve purely by the pointer; there is no fixed priority.
- Data path: at each edge where a core was granted during the preceding cycle, the owner's core_sel is decoded.
  - Legal code k (1..NUM_SRC): bus_data <= source k-1, bus_valid <= 1.
  - Illegal code: bus_data holds its previous value, bus_valid <= 0, sel_err <= 1 for one cycle.
- Data latency: 1 cycle from select/source to bus_data.
- When no core is granted: bus_data holds, bus_valid=0, sel_err=0.
- The owner can change core_sel every cycle without losing the grant.
- rst mid-tenure: everything returns to reset values immediately. The first grant after release goes to the lowest-index requester at or after core 0.

Optional Feature:
BUS_MUX_PARITY_EN
- Defined: adds output bus_par (1 bit), registered alongside bus_data and equal to the XOR of bus_data. It holds with bus_data and resets to 0.
- Undefined: port absent, no parity logic.

Decomposition:
- Package bus_mux_pkg holds:
  - state encoding (IDLE, OWNED);
  - the SEL_NONE=0 constant;
  - a function returning the next requester index given request vector and pointer.
- One natural sub-module: rr_arbiter (request vector, pointer, hold/expire inputs -> one-hot grant and owner index). Decode and data register stay in the top module.

Test Plan:
1. Reset, then core_req=001 with core0 sel=1 and src0=8'hA5 -> core_gnt=001 one edge after the request; bus_data=8'hA5 and bus_valid=1 one edge later.
2. core_req=111 asserted together after reset -> grants rotate 001, 010, 100, each held exactly MAX_HOLD=4 cycles with no idle gap.
3. Only core1 requests for 10 cycles -> the grant never drops; hold counter saturates; bus_valid stays 1.
4. Owner sel=0, then sel=17, with NUM_SRC=16 -> sel_err pulses once per illegal cycle; bus_valid=0; bus_data retains 8'hA5.
5. Owner sel=16 with src15=8'h3C; rst pulsed mid-tenure -> outputs are all 0 during reset. After release, core_req=110 grants core1 first.
6. With BUS_MUX_PARITY_EN, bus_data=8'h07 -> bus_par=1; bus_data=8'h03 -> bus_par=0.
